// File: rtl/neuron_integration_sequencer_pkg.sv
// Shared types and helpers for the neuron integration sequencer.
package ranc_neuron_pkg;

  localparam int AXON_TYPE_WIDTH = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_INTEG  = 3'd2,
    S_DONE   = 3'd3,
    S_FINISH = 3'd4
  } seq_state_e;

  // Counter width able to index 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_integration_sequencer_if.sv
// Core-SRAM read port and integrator control bundle.
interface neuron_integration_sequencer_if #(
  parameter int NUM_NEURONS  = 256,
  parameter int NUM_AXONS    = 256,
  parameter int NUM_WEIGHTS  = 4,
  parameter int WEIGHT_WIDTH = 9
) ();
  import ranc_neuron_pkg::*;

  logic [cnt_width(NUM_NEURONS)-1:0]     csram_addr;
  logic [NUM_AXONS-1:0]                  csram_synapses;
  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0]   csram_weights;
  logic [WEIGHT_WIDTH-1:0]               weight;
  logic                                  next_neuron;
  logic                                  integrator_reg_en;
  logic                                  neuron_done;

  // Sequencer side: addresses the SRAM and drives the integrator.
  modport master (
    output csram_addr, weight, next_neuron, integrator_reg_en, neuron_done,
    input  csram_synapses, csram_weights
  );

  // SRAM / integrator side.
  modport slave (
    input  csram_addr, weight, next_neuron, integrator_reg_en, neuron_done,
    output csram_synapses, csram_weights
  );

endinterface

// File: rtl/neuron_integration_sequencer_weight_select.sv
// Combinational weight pick for the current axon: spike AND synapse gate,
// then the axon type chooses one of the neuron's weights.
module weight_select import ranc_neuron_pkg::*; #(
  parameter int NUM_AXONS    = 256,
  parameter int NUM_WEIGHTS  = 4,
  parameter int WEIGHT_WIDTH = 9,
  parameter int AXON_CNT_W   = cnt_width(NUM_AXONS)
) (
  input  logic [AXON_CNT_W-1:0]               axon_idx_i,
  input  logic [NUM_AXONS-1:0]                spikes_i,
  input  logic [NUM_AXONS-1:0]                synapses_i,
  input  logic [AXON_TYPE_WIDTH*NUM_AXONS-1:0] types_i,
  input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights_i,
  output logic [WEIGHT_WIDTH-1:0]             weight_o
);

  logic [AXON_TYPE_WIDTH-1:0] sel_type;

  // Gate on spike & connection; out-of-range types fall back to weight 0.
  always_comb begin
    weight_o = '0;
    sel_type = types_i[AXON_TYPE_WIDTH*axon_idx_i +: AXON_TYPE_WIDTH];
    if (spikes_i[axon_idx_i] && synapses_i[axon_idx_i]) begin
      if (int'(sel_type) < NUM_WEIGHTS) begin
        weight_o = weights_i[int'(sel_type)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end else begin
        weight_o = weights_i[0 +: WEIGHT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/neuron_integration_sequencer.sv
// Per-tick walk over all neurons and axons feeding the integrator.
//
//  state  | meaning
//  IDLE   | waiting for tick, busy low
//  FETCH  | csram row for neuron_cnt being read (1 cycle)
//  INTEG  | one axon per cycle, integrator enabled
//  DONE   | neuron_done pulse, potential final for csram_addr
//  FINISH | tick_done pulse, busy drops next cycle
module neuron_integration_sequencer import ranc_neuron_pkg::*; #(
  parameter int NUM_NEURONS  = 256,
  parameter int NUM_AXONS    = 256,
  parameter int NUM_WEIGHTS  = 4,
  parameter int WEIGHT_WIDTH = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  tick_i,
  input  logic [NUM_AXONS-1:0]                  axon_spikes_i,
  input  logic [AXON_TYPE_WIDTH*NUM_AXONS-1:0]  axon_types_i,
  output logic                                  busy_o,
  output logic                                  tick_done_o,
  output logic                                  err_overrun_o,
  neuron_integration_sequencer_if.master        bus
);

  localparam int NEURON_CNT_W = cnt_width(NUM_NEURONS);
  localparam int AXON_CNT_W   = cnt_width(NUM_AXONS);
  localparam logic [NEURON_CNT_W-1:0] LAST_NEURON = NEURON_CNT_W'(NUM_NEURONS - 1);
  localparam logic [AXON_CNT_W-1:0]   LAST_AXON   = AXON_CNT_W'(NUM_AXONS - 1);

  seq_state_e              state_q;
  logic [NEURON_CNT_W-1:0] neuron_cnt_q;
  logic [AXON_CNT_W-1:0]   axon_cnt_q;
  logic                    busy_q;
  logic                    tick_done_q;
  logic                    err_overrun_q;
  logic                    next_neuron_q;
  logic                    reg_en_q;
  logic                    neuron_done_q;
  logic [WEIGHT_WIDTH-1:0] sel_weight;

  weight_select #(
    .NUM_AXONS    (NUM_AXONS),
    .NUM_WEIGHTS  (NUM_WEIGHTS),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .AXON_CNT_W   (AXON_CNT_W)
  ) u_weight_select (
    .axon_idx_i (axon_cnt_q),
    .spikes_i   (axon_spikes_i),
    .synapses_i (bus.csram_synapses),
    .types_i    (axon_types_i),
    .weights_i  (bus.csram_weights),
    .weight_o   (sel_weight)
  );

  // Sequencing FSM with counters and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      neuron_cnt_q  <= '0;
      axon_cnt_q    <= '0;
      busy_q        <= 1'b0;
      tick_done_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      next_neuron_q <= 1'b0;
      reg_en_q      <= 1'b0;
      neuron_done_q <= 1'b0;
    end else begin
      // Any tick outside IDLE (FINISH included) is dropped and flagged.
      if (tick_i && (state_q != S_IDLE)) begin
        err_overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (tick_i) begin
            state_q      <= S_FETCH;
            neuron_cnt_q <= '0;
            axon_cnt_q   <= '0;
            busy_q       <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q       <= S_INTEG;
          axon_cnt_q    <= '0;
          reg_en_q      <= 1'b1;
          next_neuron_q <= 1'b1;
        end
        S_INTEG: begin
          next_neuron_q <= 1'b0;
          if (axon_cnt_q == LAST_AXON) begin
            state_q       <= S_DONE;
            reg_en_q      <= 1'b0;
            neuron_done_q <= 1'b1;
          end else begin
            axon_cnt_q <= axon_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          neuron_done_q <= 1'b0;
          if (neuron_cnt_q == LAST_NEURON) begin
            state_q     <= S_FINISH;
            tick_done_q <= 1'b1;
          end else begin
            state_q      <= S_FETCH;
            neuron_cnt_q <= neuron_cnt_q + 1'b1;
          end
        end
        S_FINISH: begin
          state_q     <= S_IDLE;
          tick_done_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          tick_done_q   <= 1'b0;
          next_neuron_q <= 1'b0;
          reg_en_q      <= 1'b0;
          neuron_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Weight only leaves the block while integrating.
  assign bus.weight            = (state_q == S_INTEG) ? sel_weight : '0;
  assign bus.csram_addr        = neuron_cnt_q;
  assign bus.next_neuron       = next_neuron_q;
  assign bus.integrator_reg_en = reg_en_q;
  assign bus.neuron_done       = neuron_done_q;
  assign busy_o                = busy_q;
  assign tick_done_o           = tick_done_q;
  assign err_overrun_o         = err_overrun_q;

endmodule

// File: tb/tb_neuron_integration_sequencer.sv
// Bench for neuron_integration_sequencer with a 4x4 core.
module tb_neuron_integration_sequencer;

  localparam int N     = 4;
  localparam int A     = 4;
  localparam int NW    = 4;
  localparam int WW    = 9;
  localparam int TOTAL = N * (A + 2) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick = 1'b0;
  logic [A-1:0]   spikes = '0;
  logic [2*A-1:0] types = '0;
  logic           busy, tick_done, err;

  logic [A-1:0]     syn_mem [N];
  logic [NW*WW-1:0] wt_mem  [N];
  logic [WW-1:0]    exp_w   [N][A];
  logic             exp_err = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [A-1:0]   spk;
    logic [A-1:0]   syn;
    logic [2*A-1:0] typ;
    int             w [A];
  } vec_t;

  vec_t tbl [3];

  localparam logic [NW*WW-1:0] W_STD = {9'h1FE, 9'h002, 9'h1FF, 9'h001};

  neuron_integration_sequencer_if #(
    .NUM_NEURONS(N), .NUM_AXONS(A), .NUM_WEIGHTS(NW), .WEIGHT_WIDTH(WW)
  ) bus ();

  neuron_integration_sequencer #(
    .NUM_NEURONS(N), .NUM_AXONS(A), .NUM_WEIGHTS(NW), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick),
    .axon_spikes_i (spikes),
    .axon_types_i  (types),
    .busy_o        (busy),
    .tick_done_o   (tick_done),
    .err_overrun_o (err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Core SRAM: one-cycle synchronous read.
  always @(posedge clk) begin
    bus.csram_synapses <= syn_mem[bus.csram_addr];
    bus.csram_weights  <= wt_mem[bus.csram_addr];
  end

  function automatic logic [16:0] act_vec();
    return {busy, tick_done, err, bus.csram_addr, bus.integrator_reg_en,
            bus.next_neuron, bus.neuron_done, bus.weight};
  endfunction

  // Expected outputs for cycle c after the tick: each neuron is
  // one fetch cycle, A integrate cycles, one done cycle; then one finish cycle.
  function automatic logic [16:0] model_vec(input int c);
    int k, n, ph;
    logic en;
    logic [WW-1:0] w;
    k = c - 1;
    if (c == TOTAL) return {1'b1, 1'b1, exp_err, 2'(N-1), 12'b0};
    n  = k / (A + 2);
    ph = k % (A + 2);
    en = (ph >= 1) && (ph <= A);
    w  = en ? exp_w[n][ph-1] : '0;
    return {1'b1, 1'b0, exp_err, 2'(n), en, (ph == 1), (ph == A + 1), w};
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = act_vec();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference weights straight from the rule: spike & synapse ? w[type] : 0.
  task automatic fill_model();
    for (int n = 0; n < N; n++)
      for (int a = 0; a < A; a++) begin
        int t;
        t = int'(types[2*a +: 2]);
        if (t >= NW) t = 0;
        exp_w[n][a] = (spikes[a] && syn_mem[n][a]) ? wt_mem[n][t*WW +: WW] : '0;
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Caller is just past a rising edge; tick goes high for one cycle at once.
  task automatic run_tick(input int ovr, input int abort);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    for (int c = 1; c <= TOTAL; c++) begin
      @(negedge clk);
      check($sformatf("cyc%0d", c), model_vec(c));
      if (c == abort) begin
        rst_n = 1'b0;
        exp_err = 1'b0;
        #1;
        check("async_rst", 17'b0);
        repeat (2) begin
          @(negedge clk);
          check("rst_hold", 17'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (c == ovr) tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      if (c == ovr) exp_err = 1'b1;
    end
    @(negedge clk);
    check("post_idle", {2'b00, exp_err, 2'(N-1), 12'b0});
  endtask

  task automatic load_vec(input int v);
    spikes = tbl[v].spk;
    types  = tbl[v].typ;
    for (int n = 0; n < N; n++) begin
      syn_mem[n] = tbl[v].syn;
      wt_mem[n]  = W_STD;
      for (int a = 0; a < A; a++) exp_w[n][a] = WW'(tbl[v].w[a]);
    end
  endtask

  initial begin
    tbl[0] = '{spk: 4'b1111, syn: 4'b1111, typ: {2'd3, 2'd2, 2'd1, 2'd0}, w: '{1, -1, 2, -2}};
    tbl[1] = '{spk: 4'b0101, syn: 4'b0011, typ: {2'd2, 2'd2, 2'd2, 2'd2}, w: '{2, 0, 0, 0}};
    tbl[2] = '{spk: 4'b1010, syn: 4'b1111, typ: {2'd3, 2'd3, 2'd0, 2'd1}, w: '{0, 1, 0, -2}};
    for (int n = 0; n < N; n++) begin
      syn_mem[n] = '0;
      wt_mem[n]  = '0;
    end

    // Reset idle: no tick, everything low for 20 cycles.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", 17'b0);
      @(posedge clk);
      #1;
    end

    // Table vectors, back to back (each tick one cycle after tick_done).
    for (int v = 0; v < 3; v++) begin
      load_vec(v);
      run_tick(0, 0);
    end
    load_vec(0);
    run_tick(0, 0);

    // Randomised rows, weights, spikes and types.
    for (int r = 0; r < 6; r++) begin
      spikes = A'($urandom);
      types  = (2*A)'($urandom);
      for (int n = 0; n < N; n++) begin
        syn_mem[n] = A'($urandom);
        for (int k = 0; k < NW; k++) wt_mem[n][k*WW +: WW] = WW'($urandom_range(0, 511));
      end
      fill_model();
      run_tick(0, 0);
    end

    // Overrun mid-tick: ignored, sticky flag, timing unchanged.
    load_vec(0);
    run_tick(10, 0);
    run_tick(0, 0);

    // Overrun in the FINISH cycle: flagged, no restart.
    do_reset();
    load_vec(1);
    run_tick(TOTAL, 0);
    @(negedge clk);
    check("finish_ovr_idle", {2'b00, 1'b1, 2'(N-1), 12'b0});
    @(posedge clk);
    #1;

    // Reset during neuron 2 integration, then a clean restart from neuron 0.
    load_vec(0);
    run_tick(0, 2 * (A + 2) + 3);
    load_vec(2);
    run_tick(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
